if_inst_resp_buffer: RTL

- Sits between the instruction-SRAM-like port (or the icache response side) and the IF stage.
- Tracks outstanding fetch requests and drops responses that belong to flushed fetches.
- Responses that arrive while IF is stalled by ID are held in a small FIFO; the FIFO head is presented as inst_rdata_buffer_ok/rdata.
- Provides the data_ok/buffer_ok pair that gates IF ready_go, and back-pressures pre-IF so the buffer can never overflow.

---
 rtl/if_inst_resp_buffer_pkg.sv | 22 ++
 rtl/if_inst_resp_buffer_fifo.sv | 56 +++++
 rtl/if_inst_resp_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/if_inst_resp_buffer_pkg.sv
// Shared types and constants for the IF instruction response buffer.
// Bus width macros size the packed {ok, data} pairs handed to IF.
`ifndef IF_INST_RESP_BUFFER_PKG_SV
`define IF_INST_RESP_BUFFER_PKG_SV

`define IF_INST_BUF_BUS_W(w) (1 + (w))
`define IF_INST_RESP_BUS_W(w) (1 + (w))

package if_inst_resp_buffer_pkg;

  localparam int InstWidth = 32;
  localparam int OutstandingMax = 2;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_WAIT,
    RS_DISCARD
  } resp_state_e;

endpackage

`endif

// File: rtl/if_inst_resp_buffer_fifo.sv
// Small sync FIFO holding responses while IF is stalled.
// Flush empties it on the next edge and overrides push/pop.
module if_inst_resp_buffer_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && ((count != CW'(DEPTH)) || pop_en);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_en) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/if_inst_resp_buffer.sv
// IF response filter/buffer: drops flushed responses, holds stalled ones.
// Optional INST_RESP_DISCARD_STAT_EN adds a dropped-response counter.
module if_inst_resp_buffer
  import if_inst_resp_buffer_pkg::*;
#(
  parameter int DATA_WIDTH      = InstWidth,
  parameter int OUTSTANDING_MAX = OutstandingMax,
  parameter int CNT_WIDTH       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_sram_req_i,
  input  logic                  inst_sram_addr_ok_i,
  input  logic                  inst_sram_data_ok_i,
  input  logic [DATA_WIDTH-1:0] inst_sram_rdata_i,
  input  logic                  if_valid_i,
  input  logic                  id_allowin_i,
  input  logic                  excep_flush_i,
  output logic                  inst_sram_data_ok_o,
  output logic [DATA_WIDTH-1:0] inst_rdata_o,
  output logic                  inst_rdata_buffer_ok_o,
  output logic [DATA_WIDTH-1:0] inst_rdata_buffer_rdata_o,
  output logic                  preif_req_block_o,
  output logic                  discard_pending_o
`ifdef INST_RESP_DISCARD_STAT_EN
  ,
  output logic [31:0]           discard_total_o
`endif
);

  logic                  acc;
  logic                  dok;
  logic                  take;
  logic                  pop;
  logic                  push;
  logic [CNT_WIDTH-1:0]  out_cnt;
  logic [CNT_WIDTH-1:0]  out_cnt_nxt;
  logic [CNT_WIDTH-1:0]  disc_cnt;
  logic [CNT_WIDTH-1:0]  disc_cnt_nxt;
  logic                  fifo_empty;
  logic [CNT_WIDTH-1:0]  fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_WIDTH:0]    inflight;
  resp_state_e           state;
  resp_state_e           state_nxt;

  logic [`IF_INST_BUF_BUS_W(DATA_WIDTH)-1:0]  buf_bus;
  logic [`IF_INST_RESP_BUS_W(DATA_WIDTH)-1:0] resp_bus;

  assign acc  = inst_sram_req_i && inst_sram_addr_ok_i;
  assign dok  = inst_sram_data_ok_i && (disc_cnt == '0)
             && !excep_flush_i;
  assign take = if_valid_i && id_allowin_i && !excep_flush_i;
  assign pop  = take && !fifo_empty;
  // Empty FIFO + IF handoff: IF consumes the response directly.
  assign push = dok && !(fifo_empty && take);

  assign out_cnt_nxt = out_cnt + CNT_WIDTH'(acc)
                     - CNT_WIDTH'(inst_sram_data_ok_i);

  always_comb begin
    disc_cnt_nxt = disc_cnt;
    if (excep_flush_i)
      disc_cnt_nxt = out_cnt - CNT_WIDTH'(inst_sram_data_ok_i);
    else if (inst_sram_data_ok_i && disc_cnt != '0)
      disc_cnt_nxt = disc_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt  <= '0;
      disc_cnt <= '0;
    end else begin
      out_cnt  <= out_cnt_nxt;
      disc_cnt <= disc_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RS_IDLE: begin
        if (acc) state_nxt = RS_WAIT;
      end
      RS_WAIT: begin
        if (excep_flush_i && disc_cnt_nxt != '0)
          state_nxt = RS_DISCARD;
        else if (out_cnt_nxt == '0)
          state_nxt = RS_IDLE;
      end
      RS_DISCARD: begin
        if (disc_cnt_nxt == '0)
          state_nxt = (out_cnt_nxt != '0) ? RS_WAIT : RS_IDLE;
      end
      default: state_nxt = RS_IDLE;
    endcase
  end

  always_comb begin
    discard_pending_o = (state == RS_DISCARD);
  end

  if_inst_resp_buffer_fifo #(
    .DEPTH (OUTSTANDING_MAX),
    .WIDTH (DATA_WIDTH),
    .CW    (CNT_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (excep_flush_i),
    .wdata (inst_sram_rdata_i),
    .empty (fifo_empty),
    .count (fifo_cnt),
    .head  (fifo_head)
  );

  assign inflight = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign preif_req_block_o =
    (inflight >= (CNT_WIDTH+1)'(OUTSTANDING_MAX)) || (disc_cnt != '0);

  assign buf_bus  = {!fifo_empty, fifo_head};
  assign resp_bus = {dok, inst_sram_rdata_i};
  assign {inst_rdata_buffer_ok_o, inst_rdata_buffer_rdata_o} = buf_bus;
  assign {inst_sram_data_ok_o, inst_rdata_o} = resp_bus;

`ifdef INST_RESP_DISCARD_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) discard_total_o <= '0;
    else if (inst_sram_data_ok_i && !dok)
      discard_total_o <= discard_total_o + 32'd1;
  end
`endif

endmodule
